// File: rtl/timer_irq_source_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : timer_irq_source_pkg
//  Purpose  : Register map, CTRL field positions, mode codes and FSM state
//             encodings shared by the countdown timer interrupt source.
//  Revision : 1.0  initial release
// ============================================================================
package timer_irq_source_pkg;

  // Word offsets within the timer's bridge window (address[3:2])
  localparam logic [1:0] TMR_CTRL   = 2'd0;
  localparam logic [1:0] TMR_PRESET = 2'd1;
  localparam logic [1:0] TMR_COUNT  = 2'd2;

  // CTRL bit positions
  localparam int CTRL_EN      = 0;
  localparam int CTRL_MODE_LO = 1;
  localparam int CTRL_MODE_HI = 2;
  localparam int CTRL_IM      = 3;
  localparam int CTRL_W       = 4;

  // Mode codes; 2 and 3 fall back to one-shot behaviour
  localparam logic [1:0] TMR_ONESHOT = 2'd0;
  localparam logic [1:0] TMR_RELOAD  = 2'd1;

  typedef enum logic [1:0] {
    TMR_IDLE = 2'd0,
    TMR_LOAD = 2'd1,
    TMR_CNT  = 2'd2,
    TMR_INT  = 2'd3
  } tmr_state_t;

  // Only the explicit reload code auto-restarts; every other code is one-shot
  function automatic logic is_reload(input logic [1:0] mode);
    return (mode == TMR_RELOAD);
  endfunction

endpackage : timer_irq_source_pkg
`default_nettype wire

// File: rtl/timer_irq_source.sv
`default_nettype none
// ============================================================================
//  Module   : timer_irq_source
//  Purpose  : Memory-mapped countdown timer driving a level interrupt into
//             CP0 HWInt. One-shot or auto-reload, maskable output.
//  Revision : 1.0  initial release
// ============================================================================
module timer_irq_source
  import timer_irq_source_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  addr,
  input  logic        we,
  input  logic [31:0] din,
  output logic [31:0] dout,
  output logic        irq
);

  logic [CTRL_W-1:0] r_ctrl,     w_ctrl_nxt;
  logic [31:0]       r_preset,   w_preset_nxt;
  logic [31:0]       r_count,    w_count_nxt;
  logic              r_irq_pend, w_irq_pend_nxt;
  tmr_state_t        r_state,    w_state_nxt;

  logic w_wr_ctrl;
  logic w_wr_preset;
  logic w_en;
  logic [1:0] w_mode;

  assign w_wr_ctrl   = we && (addr == TMR_CTRL);
  assign w_wr_preset = we && (addr == TMR_PRESET);
  assign w_en        = r_ctrl[CTRL_EN];
  assign w_mode      = r_ctrl[CTRL_MODE_HI:CTRL_MODE_LO];

  // State register: every register returns to zero on synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ctrl     <= '0;
      r_preset   <= '0;
      r_count    <= '0;
      r_irq_pend <= 1'b0;
      r_state    <= TMR_IDLE;
    end else begin
      r_ctrl     <= w_ctrl_nxt;
      r_preset   <= w_preset_nxt;
      r_count    <= w_count_nxt;
      r_irq_pend <= w_irq_pend_nxt;
      r_state    <= w_state_nxt;
    end
  end

  // Next-state logic; a CTRL/PRESET write suppresses the whole FSM step
  always_comb begin
    w_ctrl_nxt     = r_ctrl;
    w_preset_nxt   = r_preset;
    w_count_nxt    = r_count;
    w_irq_pend_nxt = r_irq_pend;
    w_state_nxt    = r_state;

    case (r_state)
      TMR_IDLE: begin
        if (w_en) w_state_nxt = TMR_LOAD;
      end
      TMR_LOAD: begin
        w_count_nxt = r_preset;
        w_state_nxt = TMR_CNT;
      end
      TMR_CNT: begin
        if (!w_en) begin
          // Disabling freezes COUNT where it stands
          w_state_nxt = TMR_IDLE;
        end else if (r_count > 32'd1) begin
          w_count_nxt = r_count - 32'd1;
        end else begin
          // COUNT of 0 or 1 both terminate, so PRESET=0 acts like PRESET=1
          w_count_nxt    = '0;
          w_irq_pend_nxt = 1'b1;
          w_state_nxt    = TMR_INT;
        end
      end
      TMR_INT: begin
        w_state_nxt = TMR_IDLE;
        if (is_reload(w_mode)) begin
          w_irq_pend_nxt = 1'b0;
        end else begin
          w_ctrl_nxt[CTRL_EN] = 1'b0;
        end
      end
      default: w_state_nxt = TMR_IDLE;
    endcase

    // Software write acts as the interrupt acknowledge and restarts from IDLE
    if (w_wr_ctrl || w_wr_preset) begin
      w_ctrl_nxt     = r_ctrl;
      w_preset_nxt   = r_preset;
      w_count_nxt    = r_count;
      w_irq_pend_nxt = 1'b0;
      w_state_nxt    = TMR_IDLE;
      if (w_wr_ctrl)   w_ctrl_nxt   = din[CTRL_W-1:0];
      if (w_wr_preset) w_preset_nxt = din;
    end
  end

  // Read mux reflects the registers as of the last edge
  always_comb begin
    dout = '0;
    case (addr)
      TMR_CTRL:   dout = {{(32-CTRL_W){1'b0}}, r_ctrl};
      TMR_PRESET: dout = r_preset;
      TMR_COUNT:  dout = r_count;
      default:    dout = '0;
    endcase
  end

  assign irq = r_irq_pend & r_ctrl[CTRL_IM];

endmodule : timer_irq_source
`default_nettype wire

// File: tb/tb_timer_irq_source.sv
`default_nettype none
// ============================================================================
//  Module   : tb_timer_irq_source
//  Purpose  : Directed self-checking bench for timer_irq_source.
//  Revision : 1.0  initial release
// ============================================================================
module tb_timer_irq_source;

  logic        clk;
  logic        reset;
  logic [1:0]  addr;
  logic        we;
  logic [31:0] din;
  logic [31:0] dout;
  logic        irq;

  int n_checks;
  int n_errors;

  timer_irq_source dut (
    .clk   (clk),
    .reset (reset),
    .addr  (addr),
    .we    (we),
    .din   (din),
    .dout  (dout),
    .irq   (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check, reports mismatches
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one edge; inputs are driven and outputs sampled 1 ns after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    addr = a;
    din  = d;
    we   = 1'b1;
    tick();
    we   = 1'b0;
    din  = '0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    addr = a;
    #1;
    d = dout;
  endtask

  logic [31:0] rd;
  int          hi_cnt;
  int          pulses;
  int          pulse_at [4];
  int          wait_cyc;

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset = 1'b1;
    addr  = 2'd0;
    we    = 1'b0;
    din   = '0;

    // 1. Reset
    tick();
    tick();
    reset = 1'b0;
    check("rst_irq", {31'b0, irq}, 32'd0);
    bus_read(2'd0, rd); check("rst_ctrl",   rd, 32'd0);
    bus_read(2'd1, rd); check("rst_preset", rd, 32'd0);
    bus_read(2'd2, rd); check("rst_count",  rd, 32'd0);

    // 2. One-shot, PRESET=5: LOAD after edge t+1, COUNT=5 after t+2, pend after t+7
    bus_write(2'd1, 32'd5);
    bus_write(2'd0, 32'h9);
    addr = 2'd2;
    for (int k = 1; k <= 7; k++) begin
      logic [31:0] exp_cnt;
      tick();
      exp_cnt = (k < 2) ? 32'd0 : 32'(7 - k);
      check($sformatf("os_count_e%0d", k), dout, exp_cnt);
      check($sformatf("os_irq_e%0d", k), {31'b0, irq}, (k == 7) ? 32'd1 : 32'd0);
    end
    hi_cnt = 0;
    for (int k = 0; k < 50; k++) begin
      tick();
      if (irq) hi_cnt++;
    end
    check("os_irq_hold50", hi_cnt, 32'd50);
    bus_read(2'd0, rd); check("os_ctrl_en_cleared", rd, 32'h8);
    bus_write(2'd0, 32'h0);
    check("os_ack_irq", {31'b0, irq}, 32'd0);

    // 3. Auto-reload, PRESET=3: pulses after edges t+5, t+11, t+17, t+23
    bus_write(2'd1, 32'd3);
    bus_write(2'd0, 32'hB);
    pulses = 0;
    for (int k = 1; k <= 26; k++) begin
      tick();
      if (irq) begin
        if (pulses < 4) pulse_at[pulses] = k;
        pulses++;
      end
    end
    check("ar_pulses", pulses, 32'd4);
    for (int p = 0; p < 4; p++)
      check($sformatf("ar_pulse%0d_edge", p), pulse_at[p], 32'(5 + 6 * p));
    bus_read(2'd0, rd); check("ar_ctrl_en_kept", rd, 32'hB);
    bus_write(2'd0, 32'h0);

    // 4. Masked: pend set with IM=0, irq never rises
    bus_write(2'd1, 32'd2);
    bus_write(2'd0, 32'h1);
    hi_cnt = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (irq) hi_cnt++;
    end
    check("mk_irq_low", hi_cnt, 32'd0);
    bus_read(2'd2, rd); check("mk_count_zero", rd, 32'd0);
    bus_read(2'd0, rd); check("mk_ctrl_en_cleared", rd, 32'h0);
    bus_write(2'd0, 32'h8);
    hi_cnt = 0;
    for (int k = 0; k < 3; k++) begin
      if (irq) hi_cnt++;
      tick();
    end
    check("mk_unmask_irq_low", hi_cnt, 32'd0);
    bus_write(2'd0, 32'h0);

    // 5. Collision: PRESET=4, CNT->INT edge is t+6; PRESET write lands there
    bus_write(2'd1, 32'd4);
    bus_write(2'd0, 32'h9);
    for (int k = 0; k < 5; k++) tick();
    bus_write(2'd1, 32'd7);
    check("col_irq", {31'b0, irq}, 32'd0);
    bus_read(2'd1, rd); check("col_preset", rd, 32'd7);
    bus_read(2'd2, rd); check("col_count_held", rd, 32'd1);
    // From IDLE (EN still 1): LOAD next edge, then COUNT=7
    tick();
    bus_read(2'd2, rd); check("col_idle_to_load", rd, 32'd1);
    tick();
    bus_read(2'd2, rd); check("col_reload", rd, 32'd7);
    bus_write(2'd0, 32'h0);

    // PRESET=0 and PRESET=1 both raise irq 3 edges after the CTRL write
    for (int pv = 0; pv <= 1; pv++) begin
      bus_write(2'd1, 32'(pv));
      bus_write(2'd0, 32'h9);
      wait_cyc = 0;
      while (!irq && wait_cyc < 20) begin
        tick();
        wait_cyc++;
      end
      check($sformatf("p%0d_latency", pv), wait_cyc, 32'd3);
      bus_write(2'd0, 32'h0);
    end

    // 6. Reset mid-count: PRESET=100, COUNT=40 after edge t+62
    bus_write(2'd1, 32'd100);
    bus_write(2'd0, 32'h9);
    addr = 2'd2;
    for (int k = 0; k < 62; k++) tick();
    check("rm_count40", dout, 32'd40);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus_read(2'd0, rd); check("rm_ctrl",   rd, 32'd0);
    bus_read(2'd1, rd); check("rm_preset", rd, 32'd0);
    bus_read(2'd2, rd); check("rm_count",  rd, 32'd0);
    check("rm_irq", {31'b0, irq}, 32'd0);
    hi_cnt = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (irq) hi_cnt++;
    end
    check("rm_irq_stays_low", hi_cnt, 32'd0);
    bus_read(2'd2, rd); check("rm_count_stays0", rd, 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule : tb_timer_irq_source
`default_nettype wire
